// File: rtl/mem_stage_lsu.sv
// ============================================================================
// mem_stage_lsu -- MEM-stage load/store unit
//
// Sits between the EX/MEM and MEM/WB pipeline registers. A load or store
// issues exactly one data-memory access over a req/ack bus. The pipeline is
// stalled until the access completes or times out. Store data is replicated
// across byte lanes with matching byte enables. Load data is shifted down
// and sign- or zero-extended. The ALU result and the control bits are
// forwarded to MEM/WB, and RegWrite is gated to form bubbles while stalled.
//
// Timing of one memory operation: one IDLE cycle (decode and latch), then
// N REQ cycles (the ack cycle is included), then one RESP cycle.
// StallM is high for 1 + N cycles.
//
// Parameters
//   TIMEOUT_CYC   maximum number of REQ cycles without dmem_ack before a bus
//                 error is raised (>= 1)
//
// Configuration macro
//   MEM_MISALIGN_TRAP_EN  when defined, adds output MisalignM. A misaligned
//                         access is refused in IDLE: no request, no stall.
//                         When undefined, misaligned accesses are aligned down.
//
// Ports
//   clk, reset          clock (rising edge), synchronous active-low reset
//   ValidM .. Funct3M   EX/MEM register contents
//   dmem_*              data-memory request/response bus
//   StallM              freeze PC, IF/ID, ID/EX, EX/MEM
//   BusErrM             one-cycle pulse (the RESP cycle) after a timeout
//   ReadDataM .. MemToRegMW   values for the MEM/WB register
//   MisalignM           misaligned-access flag (only with the macro defined)
// ============================================================================
module mem_stage_lsu #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ValidM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic        MemToRegM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        BusErrM,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        MisalignM,
`endif
    output logic [31:0] ReadDataM,
    output logic [31:0] ALUResultMW,
    output logic [4:0]  RdMW,
    output logic        RegWriteMW,
    output logic        MemToRegMW
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [1:0]       off_q;
    logic [2:0]       f3_q;
    logic [31:0]      rdata_q;
    logic             buserr_q;

    logic        memop;
    logic        trap;
    logic        start;
    logic        timeout;
    logic [1:0]  off_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] shifted;
    logic [31:0] load_fmt;

    assign memop = ValidM & (MemToRegM | MemWriteM);

    // A misaligned access can only be refused while it is being decoded.
`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                        (Funct3M[1] & (|ALUResultM[1:0]));
    assign trap       = (state_q == IDLE) & memop & misaligned;
    assign MisalignM  = trap;
`else
    assign trap = 1'b0;
`endif

    // Lane offset, byte enables and replicated store data.
    // Halfword and word offsets drop the low address bits, so a misaligned
    // access is aligned down.
    // NOTE: every signal driven from always_comb is given a default at the
    // top of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        off_d   = 2'b00;
        be_d    = 4'b1111;
        wdata_d = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                off_d   = ALUResultM[1:0];
                be_d    = 4'b0001 << off_d;
                wdata_d = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                off_d   = {ALUResultM[1], 1'b0};
                be_d    = 4'b0011 << off_d;
                wdata_d = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    // Load formatting uses the offset and size latched in IDLE.
    assign shifted = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_fmt = shifted;
        case (f3_q)
            3'b000:  load_fmt = {{24{shifted[7]}},  shifted[7:0]};
            3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_fmt = {24'h000000, shifted[7:0]};
            3'b101:  load_fmt = {16'h0000,   shifted[15:0]};
            default: ;
        endcase
    end

    // An ack takes priority over a timeout in the last allowed REQ cycle.
    assign timeout = (state_q == REQ) & ~dmem_ack & (cnt_q == CNT_LAST);

    // Next-state logic and the pipeline-facing outputs.
    always_comb begin
        state_d    = state_q;
        StallM     = 1'b0;
        RegWriteMW = RegWriteM & ValidM;
        ReadDataM  = 32'h0;
        start      = 1'b0;
        case (state_q)
            IDLE: begin
                if (trap) begin
                    RegWriteMW = 1'b0;
                end else if (memop) begin
                    StallM     = 1'b1;
                    RegWriteMW = 1'b0;
                    start      = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                StallM     = 1'b1;
                RegWriteMW = 1'b0;
                if (dmem_ack || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // EX/MEM is still frozen on this instruction, so ValidM is known to be 1.
                RegWriteMW = RegWriteM;
                ReadDataM  = rdata_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments, so every register
    // in this block sees the values from before the clock edge.
    // NOTE: the request registers are small, so they are all reset. A reset
    // then leaves the bus quiet and deterministic, not only dmem_req.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            off_q    <= 2'b00;
            f3_q     <= 3'b000;
            rdata_q  <= 32'h0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            buserr_q <= 1'b0;
            if (start) begin
                we_q    <= MemWriteM;
                addr_q  <= {ALUResultM[31:2], 2'b00};
                be_q    <= be_d;
                wdata_q <= wdata_d;
                off_q   <= off_d;
                f3_q    <= Funct3M;
            end
            if (state_q == REQ) begin
                if (dmem_ack) begin
                    rdata_q <= we_q ? 32'h0 : load_fmt;
                    cnt_q   <= '0;
                end else if (timeout) begin
                    rdata_q  <= 32'h0;
                    buserr_q <= 1'b1;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign dmem_req    = (state_q == REQ);
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_be     = be_q;
    assign dmem_wdata  = wdata_q;
    assign BusErrM     = buserr_q;

    assign ALUResultMW = ALUResultM;
    assign RdMW        = RdM;
    assign MemToRegMW  = MemToRegM;

endmodule
